// File: rtl/sprite_line_fetch.sv
// sprite_line_fetch: consumes the selector's per-line slot buffer, re-reads each
// selected OAM entry, fetches the matching 16-pixel pattern row and writes the
// visible, non-transparent pixels into the line buffer after clearing it.
module sprite_line_fetch #(
  parameter int MAX_OBJ_PER_LINE = 32,
  parameter int OAM_ADDR_SIZE    = 6,
  parameter int LINE_WIDTH       = 640
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         line_prepared_i,
  input  logic [MAX_OBJ_PER_LINE-1:0][OAM_ADDR_SIZE:0] buffer_array_i,
  input  logic [9:0]                                   sy_i,
  output logic [OAM_ADDR_SIZE-1:0]                     oam_addr_o,
  input  logic [31:0]                                  oam_data_i,
  output logic [11:0]                                  spr_addr_o,
  input  logic [63:0]                                  spr_data_i,
  output logic                                         lb_we_o,
  output logic [9:0]                                   lb_addr_o,
  output logic [4:0]                                   lb_data_o,
  output logic                                         line_done_o
);

  localparam int SLOT_W = $clog2(MAX_OBJ_PER_LINE);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(MAX_OBJ_PER_LINE - 1);
  localparam logic [9:0]        CLEAR_LAST = 10'(LINE_WIDTH - 1);
  localparam logic [10:0]       LINE_END   = 11'(LINE_WIDTH);

  typedef enum logic [2:0] {
    IDLE, CLEAR, SCAN, OAM_WAIT, PAT_WAIT, DRAW, DONE
  } state_e;

  state_e                   state_q;
  logic                     lp_q, lp_prev_q;
  logic [9:0]               clr_cnt_q;
  logic [SLOT_W-1:0]        slot_q;
  logic [3:0]               pix_idx_q;
  logic [9:0]               xpos_q;
  logic                     xflip_q;
  logic                     prio_q;
  logic [63:0]              pat_q;
  logic [OAM_ADDR_SIZE-1:0] oam_addr_q;
  logic [11:0]              spr_addr_q;
  logic                     lb_we_q;
  logic [9:0]               lb_addr_q;
  logic [4:0]               lb_data_q;
  logic                     line_done_q;

  // Decode of the current slot, the OAM word and the pixel being drawn.
  logic [OAM_ADDR_SIZE:0]   slot_entry;
  logic                     slot_valid;
  logic [OAM_ADDR_SIZE-1:0] slot_oam;
  logic [9:0]               row;
  logic [3:0]               row_eff;
  logic                     on_line;
  logic [11:0]              pat_addr;
  logic [3:0]               pix_sel;
  logic [3:0]               pix;
  logic [10:0]              draw_x;
  logic                     draw_we;
  logic                     start_edge;
  state_e                   adv_state;

  assign slot_entry = buffer_array_i[slot_q];
  assign slot_valid = slot_entry[0];
  assign slot_oam   = slot_entry[OAM_ADDR_SIZE:1];

  // Rows above the sprite wrap to large values, so one unsigned test covers both sides.
  assign row        = sy_i - oam_data_i[27:18];
  assign row_eff    = oam_data_i[28] ? (4'd15 - row[3:0]) : row[3:0];
  assign on_line    = oam_data_i[31] && (row[9:4] == 6'd0);
  assign pat_addr   = {oam_data_i[7:0], row_eff};

  assign pix_sel    = xflip_q ? (4'd15 - pix_idx_q) : pix_idx_q;
  assign pix        = pat_q[{pix_sel, 2'b00} +: 4];
  // 11-bit x so pixels past the right edge are dropped instead of wrapping to 0.
  assign draw_x     = {1'b0, xpos_q} + {7'd0, pix_idx_q};
  assign draw_we    = (pix != 4'd0) && (draw_x < LINE_END);

  assign start_edge = lp_q && !lp_prev_q;
  assign adv_state  = (slot_q == '0) ? DONE : SCAN;

  // The memories sample their address at the end of the requesting state, so the
  // addresses are presented combinationally there and held afterwards.
  assign oam_addr_o  = (state_q == SCAN && slot_valid) ? slot_oam : oam_addr_q;
  assign spr_addr_o  = (state_q == OAM_WAIT && on_line) ? pat_addr : spr_addr_q;
  assign lb_we_o     = lb_we_q;
  assign lb_addr_o   = lb_addr_q;
  assign lb_data_o   = lb_data_q;
  assign line_done_o = line_done_q;

  // Line sequencer: clear pass, descending slot walk, per-sprite fetch and draw.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      lp_q        <= 1'b0;
      lp_prev_q   <= 1'b0;
      clr_cnt_q   <= '0;
      slot_q      <= '0;
      pix_idx_q   <= '0;
      xpos_q      <= '0;
      xflip_q     <= 1'b0;
      prio_q      <= 1'b0;
      pat_q       <= '0;
      oam_addr_q  <= '0;
      spr_addr_q  <= '0;
      lb_we_q     <= 1'b0;
      lb_addr_q   <= '0;
      lb_data_q   <= '0;
      line_done_q <= 1'b0;
    end else begin
      lp_q      <= line_prepared_i;
      lp_prev_q <= lp_q;
      lb_we_q   <= 1'b0;
      if (state_q != IDLE && !lp_q) begin
        // Selector withdrew the line: stop immediately, nothing more is written.
        state_q     <= IDLE;
        line_done_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_edge) begin
              state_q     <= CLEAR;
              clr_cnt_q   <= '0;
              line_done_q <= 1'b0;
            end
          end
          CLEAR: begin
            lb_we_q   <= 1'b1;
            lb_addr_q <= clr_cnt_q;
            lb_data_q <= '0;
            if (clr_cnt_q == CLEAR_LAST) begin
              state_q <= SCAN;
              slot_q  <= SLOT_LAST;
            end else begin
              clr_cnt_q <= clr_cnt_q + 10'd1;
            end
          end
          SCAN: begin
            if (slot_valid) begin
              oam_addr_q <= slot_oam;
              state_q    <= OAM_WAIT;
            end else begin
              slot_q  <= slot_q - SLOT_W'(1);
              state_q <= adv_state;
            end
          end
          OAM_WAIT: begin
            if (on_line) begin
              spr_addr_q <= pat_addr;
              xpos_q     <= oam_data_i[17:8];
              xflip_q    <= oam_data_i[29];
              prio_q     <= oam_data_i[30];
              state_q    <= PAT_WAIT;
            end else begin
              slot_q  <= slot_q - SLOT_W'(1);
              state_q <= adv_state;
            end
          end
          PAT_WAIT: begin
            pat_q     <= spr_data_i;
            pix_idx_q <= '0;
            state_q   <= DRAW;
          end
          DRAW: begin
            lb_we_q <= draw_we;
            if (draw_we) begin
              lb_addr_q <= draw_x[9:0];
              lb_data_q <= {prio_q, pix};
            end
            pix_idx_q <= pix_idx_q + 4'd1;
            if (pix_idx_q == 4'd15) begin
              slot_q  <= slot_q - SLOT_W'(1);
              state_q <= adv_state;
            end
          end
          DONE: begin
            line_done_q <= 1'b1;
            if (start_edge) begin
              state_q     <= CLEAR;
              clr_cnt_q   <= '0;
              line_done_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Scoreboard bench for sprite_line_fetch: expected line-buffer writes are queued
// by the stimulus and popped by a negedge monitor on every lb_we.
module tb_sprite_line_fetch;

  logic             clk;
  logic             rst_n;
  logic             lp;
  logic [31:0][6:0] buf_arr;
  logic [9:0]       sy;
  logic [5:0]       oam_addr;
  logic [31:0]      oam_data;
  logic [11:0]      spr_addr;
  logic [63:0]      spr_data;
  logic             lb_we;
  logic [9:0]       lb_addr;
  logic [4:0]       lb_data;
  logic             line_done;

  sprite_line_fetch #(
    .MAX_OBJ_PER_LINE(32),
    .OAM_ADDR_SIZE(6),
    .LINE_WIDTH(640)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .line_prepared_i(lp),
    .buffer_array_i(buf_arr),
    .sy_i(sy),
    .oam_addr_o(oam_addr),
    .oam_data_i(oam_data),
    .spr_addr_o(spr_addr),
    .spr_data_i(spr_data),
    .lb_we_o(lb_we),
    .lb_addr_o(lb_addr),
    .lb_data_o(lb_data),
    .line_done_o(line_done)
  );

  typedef struct packed {
    logic [9:0] addr;
    logic [4:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_w;
  logic [31:0] oam_mem [64];
  logic [63:0] pat_mem [4096];
  logic [4:0]  lb_model [1024];
  int          total = 0;
  int          bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous OAM and pattern memories, one cycle of read latency.
  always @(posedge clk) begin
    oam_data <= oam_mem[oam_addr];
    spr_data <= pat_mem[spr_addr];
  end

  // Monitor: every line-buffer write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && lb_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL lb_write unexpected: got addr=%0d data=%02h want no write", lb_addr, lb_data);
      end else begin
        mon_w = exp_q.pop_front();
        if (lb_addr !== mon_w.addr || lb_data !== mon_w.data) begin
          bad++;
          $display("FAIL lb_write: got addr=%0d data=%02h want addr=%0d data=%02h",
                   lb_addr, lb_data, mon_w.addr, mon_w.data);
        end
      end
      lb_model[lb_addr] = lb_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_lb_we"},     32'(lb_we),     32'd0);
    chk({nm, "_lb_addr"},   32'(lb_addr),   32'd0);
    chk({nm, "_lb_data"},   32'(lb_data),   32'd0);
    chk({nm, "_line_done"}, 32'(line_done), 32'd0);
    chk({nm, "_oam_addr"},  32'(oam_addr),  32'd0);
    chk({nm, "_spr_addr"},  32'(spr_addr),  32'd0);
  endtask

  task automatic push_range(input int lo, input int hi, input logic [4:0] d);
    wr_t w;
    for (int x = lo; x <= hi; x++) begin
      w.addr = 10'(x);
      w.data = d;
      exp_q.push_back(w);
    end
  endtask

  function automatic logic [31:0] mk_oam(input logic en, input logic pr, input logic xf,
                                         input logic yf, input logic [9:0] yp,
                                         input logic [9:0] xp, input logic [7:0] rf);
    return {en, pr, xf, yf, yp, xp, rf};
  endfunction

  // Drop line_prepared long enough to return to IDLE, then raise it.
  task automatic start_line();
    lp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    lp = 1'b1;
  endtask

  // Cycles are counted from the clock edge that registers line_prepared high.
  task automatic run_line(input int exp_done, input string nm);
    int n;
    bit seen;
    start_line();
    @(posedge clk);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (line_done === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen || n != exp_done) begin
      bad++;
      $display("FAIL %s_done_cycle: got=%0d (seen=%0d) want=%0d", nm, n, seen, exp_done);
    end
    $display("line %s: line_done after %0d cycles", nm, n);
    chk({nm, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic setup_overlap();
    buf_arr    = '0;
    buf_arr[0] = {6'd11, 1'b1};
    buf_arr[1] = {6'd10, 1'b1};
    buf_arr[2] = {6'd12, 1'b1};
    buf_arr[3] = {6'd13, 1'b1};
    oam_mem[10] = mk_oam(1'b1, 1'b0, 1'b0, 1'b0, 10'd100, 10'd50, 8'd5);
    oam_mem[11] = mk_oam(1'b1, 1'b1, 1'b0, 1'b0, 10'd100, 10'd50, 8'd6);
    oam_mem[12] = mk_oam(1'b0, 1'b0, 1'b0, 1'b0, 10'd100, 10'd300, 8'd7);
    oam_mem[13] = mk_oam(1'b1, 1'b0, 1'b0, 1'b0, 10'd200, 10'd300, 8'd7);
    pat_mem[12'h053] = 64'h2222_2222_2222_2222;
    pat_mem[12'h063] = 64'h7777_7777_7777_7777;
    pat_mem[12'h073] = 64'h9999_9999_9999_9999;
    sy = 10'd103;
  endtask

  initial begin
    bit found;
    rst_n   = 1'b0;
    lp      = 1'b0;
    sy      = 10'd0;
    buf_arr = '0;
    for (int i = 0; i < 64; i++) oam_mem[i] = '0;
    for (int i = 0; i < 4096; i++) pat_mem[i] = '0;
    for (int i = 0; i < 1024; i++) lb_model[i] = 5'h1F;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    // Reset in the middle of the clear pass
    push_range(0, 639, 5'h00);
    start_line();
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_idle_outputs("midline_reset");
    lp = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Clear only: 640 clear writes, 32 one-cycle scans
    push_range(0, 639, 5'h00);
    run_line(674, "clear_only");
    chk("clear_only_spr_addr", 32'(spr_addr), 32'h000);

    // Single sprite, pixel 0 transparent
    buf_arr    = '0;
    buf_arr[0] = {6'd5, 1'b1};
    oam_mem[5] = mk_oam(1'b1, 1'b0, 1'b0, 1'b0, 10'd100, 10'd200, 8'd3);
    pat_mem[12'h033] = 64'hFFFF_FFFF_FFFF_FFF0;
    sy = 10'd103;
    push_range(0, 639, 5'h00);
    push_range(201, 215, 5'h0F);
    run_line(692, "single");
    chk("single_spr_addr", 32'(spr_addr), 32'h033);
    chk("single_oam_addr", 32'(oam_addr), 32'd5);
    chk("single_x200_untouched", 32'(lb_model[200]), 32'h00);

    // x and y flip
    oam_mem[5] = mk_oam(1'b1, 1'b0, 1'b1, 1'b1, 10'd100, 10'd200, 8'd3);
    pat_mem[12'h03C] = 64'hFFFF_FFFF_FFFF_FFF0;
    push_range(0, 639, 5'h00);
    push_range(200, 214, 5'h0F);
    run_line(692, "flip");
    chk("flip_spr_addr", 32'(spr_addr), 32'h03C);
    chk("flip_x215_untouched", 32'(lb_model[215]), 32'h00);

    // Right edge: only x 630..639 written
    oam_mem[5] = mk_oam(1'b1, 1'b0, 1'b0, 1'b0, 10'd100, 10'd630, 8'd4);
    pat_mem[12'h043] = 64'hFFFF_FFFF_FFFF_FFFF;
    push_range(0, 639, 5'h00);
    push_range(630, 639, 5'h0F);
    run_line(692, "right_edge");
    chk("right_edge_spr_addr", 32'(spr_addr), 32'h043);
    chk("right_edge_x0_untouched", 32'(lb_model[0]), 32'h00);

    // Overlap with an off-line and a disabled slot in front
    setup_overlap();
    push_range(0, 639, 5'h00);
    push_range(50, 65, 5'h02);
    push_range(50, 65, 5'h17);
    run_line(712, "overlap");
    chk("overlap_spr_addr", 32'(spr_addr), 32'h063);
    for (int x = 50; x <= 65; x++) chk($sformatf("overlap_final_x%0d", x), 32'(lb_model[x]), 32'h17);
    chk("overlap_x66_clear", 32'(lb_model[66]), 32'h00);

    // Abort during the draw of slot 1, then restart
    push_range(0, 639, 5'h00);
    push_range(50, 55, 5'h02);
    start_line();
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge clk);
      if (lb_we === 1'b1 && lb_addr === 10'd54 && lb_data === 5'h02) found = 1'b1;
    end
    lp = 1'b0;
    chk("abort_trigger_seen", 32'(found), 32'd1);
    repeat (40) @(negedge clk);
    chk("abort_line_done", 32'(line_done), 32'd0);
    chk("abort_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("line abort: dropped during slot 1 draw");
    exp_q.delete();
    push_range(0, 639, 5'h00);
    push_range(50, 65, 5'h02);
    push_range(50, 65, 5'h17);
    run_line(712, "restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_line_fetch.md
Name: sprite_line_fetch

Overview:
- Sits directly downstream of the per-line sprite selector.
- Consumes its 32-slot buffer of selected OAM indices once the selector reports the line is prepared.
- Re-reads each selected OAM entry and fetches the 16-pixel sprite row from sprite pattern memory.
- Writes the visible, non-transparent pixels into a line buffer that the scan-out stage reads on the following line.

Parameters:
- MAX_OBJ_PER_LINE, 32, number of slots in buffer_array.
- OAM_ADDR_SIZE, 6, OAM address width; a slot is OAM_ADDR_SIZE+1 bits wide.
- LINE_WIDTH, 640, visible pixels per line; also the length of the clear pass.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- line_prepared  in  1  selector done flag; level signal, falls when sy changes.
- buffer_array  in  MAX_OBJ_PER_LINE x (OAM_ADDR_SIZE+1)  slot k: bit0 = valid, bits[OAM_ADDR_SIZE:1] = OAM index.
- sy  in  10  current line number.
- oam_addr  out  OAM_ADDR_SIZE  OAM read address; synchronous OAM, 1-cycle latency.
- oam_data  in  32  OAM word: [31] enable, [30] priority, [29] xflip, [28] yflip, [27:18] ypos, [17:8] xpos, [7:0] spriteref.
- spr_addr  out  12  pattern address {spriteref, row[3:0]}; synchronous, 1-cycle latency.
- spr_data  in  64  16 pixels x 4 bits; pixel i = bits[4i+3:4i]; value 0 = transparent.
- lb_we  out  1  line buffer write enable.
- lb_addr  out  10  line buffer pixel address.
- lb_data  out  5  {priority, colour[3:0]}.
- line_done  out  1  level; high when the line buffer is complete for sy.

Behaviour:
- Reset values: oam_addr=0, spr_addr=0, lb_we=0, lb_addr=0, lb_data=0, line_done=0, state=IDLE.
- Start: a 0->1 edge of registered line_prepared, seen in IDLE or DONE, moves to CLEAR on the next cycle. line_done clears at that point.
- CLEAR:
  - Writes lb_data=0 to lb_addr 0..LINE_WIDTH-1, one per cycle: LINE_WIDTH cycles with lb_we=1.
  - Then slot=MAX_OBJ_PER_LINE-1, go to SCAN.
- Slot order: slots are processed in descending order (31 down to 0). The lowest slot is written last, so it wins overlaps.
- SCAN (1 cycle):
  - Valid slot: oam_addr=slot index, go to OAM_WAIT.
  - Invalid slot: decrement slot. Go to DONE if slot was 0, otherwise stay in SCAN.
- OAM_WAIT (1 cycle): oam_data is valid in this cycle.
  - row = (sy - ypos) as 10-bit subtraction.
  - Skip the slot (same exit as invalid) if enable=0 or row>15.
  - Otherwise: effective row = yflip ? 15-row[3:0] : row[3:0]. Drive spr_addr={spriteref, effective row}, latch xpos, xflip and priority, go to PAT_WAIT.
- PAT_WAIT (1 cycle): latch spr_data, go to DRAW with i=0.
- DRAW (16 cycles, i=0..15):
  - pix = xflip ? pixel(15-i) : pixel(i); x = xpos + i, computed 11 bits wide.
  - lb_we = (pix!=0) && (x < LINE_WIDTH); lb_addr=x[9:0]; lb_data={priority, pix}.
  - After i=15: next slot, or DONE.
- Slot cost: valid and drawn = 19 cycles; disabled or off-line = 2 cycles; invalid slot = 1 cycle.
- DONE: line_done=1, lb_we=0. Held until the next start edge or abort.
- Abort: line_prepared going low in any state other than IDLE returns to IDLE on the next cycle, with lb_we=0 and line_done=0 from that cycle. No partial write is issued after the abort cycle.
- Simultaneous abort and start edge: abort wins.
- Reset mid-line: everything returns to reset values immediately.
- x wrap: xpos+i >= LINE_WIDTH is never written. There is no wrap to address 0.
- oam_addr and spr_addr hold their last values outside the states that drive them.

Test Plan:
- Clear only: all slots invalid, line_prepared 0->1 -> 640 writes of data 0 at addr 0..639, then 32 SCAN cycles, then line_done=1 exactly 674 cycles after the edge.
- Single sprite, slot 0 = OAM 5 {enable=1, ypos=100, xpos=200, spriteref=3}, sy=103, spr_data pixels 1..15 = 0xF:
  - Checks: spr_addr=0x033.
  - Checks: writes at lb_addr 201..215, data 0x0F; pixel 0 not written.
- Flips: same sprite with xflip=1, yflip=1 -> spr_addr=0x03C; pixel 15 lands at x=200, pixel 0 (transparent) at 215 is not written.
- Right edge: xpos=630 -> writes only at x 630..639; no lb_we for i>=10.
- Overlap: slots 0 and 1 cover the same x; slot 1 colour 2, slot 0 colour 7 -> the last write per x carries colour 7.
- Abort: line_prepared falls during DRAW of slot 1 -> lb_we=0 from the next cycle, line_done stays 0, state returns to IDLE; the next 0->1 edge restarts from CLEAR.
